// File: rtl/sc_downspeed_pkg.sv
// sc_downspeed_pkg: shared state encoding and reload computation for the Frogger speed timer.
// Rev 1.0
`default_nettype none

package sc_downspeed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // Wide arithmetic so any parameter set fits; an underflowing subtraction clamps to the floor.
  function automatic logic [63:0] calc_reload(input logic [63:0] base,
                                              input logic [63:0] step,
                                              input logic [63:0] min_reload,
                                              input logic [63:0] level);
    logic [63:0] dec;
    logic [63:0] diff;
    dec  = level * step;
    diff = base - dec;
    if (dec > base) begin
      return min_reload;
    end
    if (diff < min_reload) begin
      return min_reload;
    end
    return diff;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_edgedetect_inlow.sv
// sc_edgedetect_inlow: falling-edge detector for active-low buttons; history resets to released.
// Rev 1.0
`default_nettype none

module sc_edgedetect_inlow (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 1'b1;
    end else begin
      hist <= din;
    end
  end

  assign fall = hist & ~din;

endmodule

`default_nettype wire

// File: rtl/sc_downspeedtimer.sv
// sc_downspeedtimer: loadable down-counting game-tick timer with level-selected reload.
// Rev 1.0
`default_nettype none

module sc_downspeedtimer
  import sc_downspeed_pkg::*;
#(
  parameter int DOWNSPEED_DATAWIDTH   = 27,
  parameter int DOWNSPEED_LEVELWIDTH  = 3,
  parameter int DOWNSPEED_BASE_RELOAD = 49999999,
  parameter int DOWNSPEED_STEP        = 6000000,
  parameter int DOWNSPEED_MIN_RELOAD  = 1000000
) (
  input  logic                            SC_DOWNSPEED_CLOCK_50,
  input  logic                            SC_DOWNSPEED_RESET_InLow,
  input  logic                            SC_DOWNSPEED_start_InLow,
  input  logic                            SC_DOWNSPEED_pause_InLow,
  input  logic                            SC_DOWNSPEED_levelUp_InLow,
  input  logic                            SC_DOWNSPEED_levelClear_InLow,
  output logic                            SC_DOWNSPEED_tick_Out,
  output logic                            SC_DOWNSPEED_running_Out,
  output logic [DOWNSPEED_DATAWIDTH-1:0]  SC_DOWNSPEED_data_OutBUS,
  output logic [DOWNSPEED_LEVELWIDTH-1:0] SC_DOWNSPEED_level_OutBUS
);

  localparam logic [DOWNSPEED_LEVELWIDTH-1:0] LEVEL_MAX = '1;

  state_t                            state, state_next;
  logic [DOWNSPEED_DATAWIDTH-1:0]    count, count_next, reload_next;
  logic [DOWNSPEED_LEVELWIDTH-1:0]   level, level_next;
  logic                              tick, tick_next;
  logic                              running;
  logic                              level_fall;

  sc_edgedetect_inlow u_levelup_edge (
    .clk   (SC_DOWNSPEED_CLOCK_50),
    .rst_n (SC_DOWNSPEED_RESET_InLow),
    .din   (SC_DOWNSPEED_levelUp_InLow),
    .fall  (level_fall)
  );

  always_comb begin
    level_next = level;
    if (!SC_DOWNSPEED_levelClear_InLow) begin
      level_next = '0;
    end else if (level_fall && (level != LEVEL_MAX)) begin
      level_next = level + DOWNSPEED_LEVELWIDTH'(1);
    end
  end

  // Reload follows the next level so a same-edge level change is seen by the reload.
  assign reload_next = DOWNSPEED_DATAWIDTH'(calc_reload(64'(DOWNSPEED_BASE_RELOAD),
                                                        64'(DOWNSPEED_STEP),
                                                        64'(DOWNSPEED_MIN_RELOAD),
                                                        64'(level_next)));

  always_comb begin
    state_next = state;
    count_next = count;
    tick_next  = 1'b0;
    case (state)
      IDLE: begin
        count_next = reload_next;
        if (!SC_DOWNSPEED_start_InLow) begin
          state_next = RUN;
        end
      end
      RUN, PAUSE: begin
        // Releasing pause resumes counting on that same edge.
        if (!SC_DOWNSPEED_pause_InLow) begin
          state_next = PAUSE;
        end else begin
          state_next = RUN;
          if (count != '0) begin
            count_next = count - DOWNSPEED_DATAWIDTH'(1);
          end else begin
            tick_next  = 1'b1;
            count_next = reload_next;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_DOWNSPEED_CLOCK_50 or negedge SC_DOWNSPEED_RESET_InLow) begin
    if (!SC_DOWNSPEED_RESET_InLow) begin
      state   <= IDLE;
      count   <= '0;
      level   <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      level   <= level_next;
      tick    <= tick_next;
      running <= (state_next == RUN);
    end
  end

  assign SC_DOWNSPEED_tick_Out     = tick;
  assign SC_DOWNSPEED_running_Out  = running;
  assign SC_DOWNSPEED_data_OutBUS  = count;
  assign SC_DOWNSPEED_level_OutBUS = level;

endmodule

`default_nettype wire

// File: tb/tb_sc_downspeedtimer.sv
// tb_sc_downspeedtimer: directed and randomized checks of the speed timer against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_sc_downspeedtimer;

  localparam int DW   = 8;
  localparam int LW   = 3;
  localparam int BASE = 9;
  localparam int STEP = 2;
  localparam int MINR = 2;
  localparam int LMAX = 7;

  logic          clk;
  logic          rst_n, start_n, pause_n, up_n, clear_n;
  logic          tick, running;
  logic [DW-1:0] data;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_started, m_paused, m_tick, m_prev_up;
  int m_count, m_level;

  sc_downspeedtimer #(
    .DOWNSPEED_DATAWIDTH   (DW),
    .DOWNSPEED_LEVELWIDTH  (LW),
    .DOWNSPEED_BASE_RELOAD (BASE),
    .DOWNSPEED_STEP        (STEP),
    .DOWNSPEED_MIN_RELOAD  (MINR)
  ) dut (
    .SC_DOWNSPEED_CLOCK_50         (clk),
    .SC_DOWNSPEED_RESET_InLow      (rst_n),
    .SC_DOWNSPEED_start_InLow      (start_n),
    .SC_DOWNSPEED_pause_InLow      (pause_n),
    .SC_DOWNSPEED_levelUp_InLow    (up_n),
    .SC_DOWNSPEED_levelClear_InLow (clear_n),
    .SC_DOWNSPEED_tick_Out         (tick),
    .SC_DOWNSPEED_running_Out      (running),
    .SC_DOWNSPEED_data_OutBUS      (data),
    .SC_DOWNSPEED_level_OutBUS     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rl(input int l);
    int r;
    r = BASE - l * STEP;
    return (r < MINR) ? MINR : r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_paused = 0; m_tick = 0; m_prev_up = 1;
    m_count = 0; m_level = 0;
  endtask

  // One clock of game-timer behaviour, from the inputs present at the edge.
  task automatic model_update();
    int  nl;
    bit  pressed;
    nl      = m_level;
    pressed = m_prev_up && !up_n;
    if (!clear_n) nl = 0;
    else if (pressed && nl < LMAX) nl = nl + 1;
    m_prev_up = up_n;
    m_tick    = 0;
    if (!m_started) begin
      m_count = rl(nl);
      if (!start_n) m_started = 1;
    end else if (!pause_n) begin
      m_paused = 1;
    end else begin
      m_paused = 0;
      if (m_count > 0) m_count = m_count - 1;
      else begin
        m_tick  = 1;
        m_count = rl(nl);
      end
    end
    m_level = nl;
  endtask

  task automatic step();
    if (!rst_n) model_reset();
    else model_update();
    @(posedge clk);
    #1;
    check("m_tick", tick, m_tick);
    check("m_running", running, m_started && !m_paused);
    check("m_data", data, m_count);
    check("m_level", level, m_level);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    check("rst_data", data, 0);
    check("rst_level", level, 0);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    step();
    rst_n = 1;
    step();
  endtask

  task automatic press();
    up_n = 0;
    step();
    up_n = 1;
    step();
  endtask

  task automatic wait_data(input int target, input int budget);
    int n;
    n = 0;
    while (data !== DW'(target) && n < budget) begin
      step();
      n++;
    end
    check("reach_data", data, target);
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < budget);
    check("tick_seen", tick, 1);
  endtask

  initial begin
    int n;
    rst_n = 0; start_n = 1; pause_n = 1; up_n = 1; clear_n = 1;
    model_reset();

    // Start and free-running countdown
    do_reset();
    check("idle_data", data, 9);
    start_n = 0;
    step();
    start_n = 1;
    check("start_running", running, 1);
    check("start_data", data, 9);
    wait_tick(15, n);
    check("first_tick_latency", n, 10);
    check("tick_reload", data, 9);
    wait_tick(15, n);
    check("tick_period", n, 10);
    check("run_level", level, 0);

    // Level presses in IDLE, reload floor and saturation
    do_reset();
    repeat (3) press();
    check("lvl3", level, 3);
    check("lvl3_data", data, 3);
    press();
    check("lvl4", level, 4);
    check("lvl4_data", data, 2);
    repeat (3) press();
    check("lvl7", level, 7);
    check("lvl7_data", data, 2);
    repeat (2) press();
    check("lvl_sat", level, 7);
    check("lvl_sat_data", data, 2);

    // Pause mid-count
    do_reset();
    start_n = 0; step(); start_n = 1;
    wait_data(5, 20);
    pause_n = 0;
    repeat (4) step();
    check("pause_data", data, 5);
    check("pause_running", running, 0);
    check("pause_tick", tick, 0);
    pause_n = 1;
    wait_tick(20, n);
    check("resume_tick_latency", n, 6);

    // Pause landing on zero defers the tick
    wait_data(0, 20);
    pause_n = 0;
    step();
    check("zero_pause_tick", tick, 0);
    check("zero_pause_data", data, 0);
    step();
    pause_n = 1;
    step();
    check("zero_resume_tick", tick, 1);
    check("zero_resume_data", data, 9);

    // Level change mid-count only affects the next reload
    wait_data(6, 20);
    up_n = 0; step(); up_n = 1;
    check("midlvl_data", data, 5);
    check("midlvl_level", level, 1);
    wait_tick(20, n);
    check("midlvl_latency", n, 6);
    check("midlvl_reload", data, 7);
    clear_n = 0; up_n = 0;
    step();
    check("clear_prio", level, 0);
    clear_n = 1; up_n = 1;
    step();

    // Asynchronous reset mid-count
    do_reset();
    press(); press();
    start_n = 0; step(); start_n = 1;
    wait_data(4, 20);
    check("pre_async_level", level, 2);
    #2 rst_n = 0;
    #1;
    check("async_data", data, 0);
    check("async_level", level, 0);
    check("async_tick", tick, 0);
    check("async_running", running, 0);
    model_reset();
    step();
    rst_n = 1;
    start_n = 0; step(); start_n = 1;
    check("post_async_data", data, 9);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      start_n = ($urandom_range(0, 9) != 0);
      pause_n = ($urandom_range(0, 4) != 0);
      up_n    = ($urandom_range(0, 1) != 0);
      clear_n = ($urandom_range(0, 19) != 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sc_downspeedtimer.md
Name: sc_downspeedtimer

Overview:
- Loadable down-counting speed timer for the Frogger game tick.
- Holds a speed level that selects a reload value. Counts down from that value and emits a one-cycle tick at zero, then auto-reloads.
- Works as the consumer end of the up-speed counting scheme: the tick drives lane/car movement, and the level is raised by game logic as the player advances.

Parameters:
- DOWNSPEED_DATAWIDTH, 27: counter width.
- DOWNSPEED_LEVELWIDTH, 3: speed level width; max level = 2^LEVELWIDTH-1.
- DOWNSPEED_BASE_RELOAD, 49999999: reload at level 0.
- DOWNSPEED_STEP, 6000000: reload decrement per level.
- DOWNSPEED_MIN_RELOAD, 1000000: reload floor; must be >=1.

Ports:
- SC_DOWNSPEED_CLOCK_50  in  1  system clock.
- SC_DOWNSPEED_RESET_InLow  in  1  asynchronous active-low reset.
- SC_DOWNSPEED_start_InLow  in  1  level; low in IDLE starts counting.
- SC_DOWNSPEED_pause_InLow  in  1  level; low freezes counting.
- SC_DOWNSPEED_levelUp_InLow  in  1  level; each high-to-low transition raises the level by one.
- SC_DOWNSPEED_levelClear_InLow  in  1  level; low forces level to 0.
- SC_DOWNSPEED_tick_Out  out  1  one-cycle pulse at countdown expiry.
- SC_DOWNSPEED_running_Out  out  1  high in RUN.
- SC_DOWNSPEED_data_OutBUS  out  DATAWIDTH  current count.
- SC_DOWNSPEED_level_OutBUS  out  LEVELWIDTH  current level.

Behaviour:
Clock, reset and reset values:
- One clock domain, SC_DOWNSPEED_CLOCK_50.
- Reset is asynchronous and active-low (SC_DOWNSPEED_RESET_InLow). Assertion at any time, including mid-count, immediately gives:
  - state = IDLE, count = 0, level = 0
  - tick = 0, running = 0
  - edge-detect history = 1 (released)

Reload computation:
- reload(L) = BASE_RELOAD - L*STEP, computed in DATAWIDTH+LEVELWIDTH bits.
- If the result underflows or is below MIN_RELOAD, reload = MIN_RELOAD.
- Combinational from the level register.

State machine (states IDLE, RUN, PAUSE; encodings from the package):
- IDLE:
  - count <= reload(level) every cycle, so level changes show immediately.
  - start_InLow = 0 -> RUN next cycle; count already holds the reload.
- RUN:
  - pause_InLow = 0 -> PAUSE; count does not decrement that cycle and tick = 0.
  - Otherwise, if count != 0: count <= count - 1.
  - Otherwise (count == 0): tick <= 1 for the next cycle only, and count <= reload(level).
  - Count never wraps.
  - Tick period = reload + 1 cycles. The first tick comes reload+1 cycles after the IDLE->RUN transition.
- PAUSE:
  - count frozen, tick = 0.
  - pause_InLow = 1 -> RUN. The count resumes from the frozen value; if frozen at 0, the tick fires on the first RUN cycle.
- start_InLow is ignored in RUN and PAUSE. There is no return to IDLE except by reset.

Level register:
- levelUp falling edge (previous 1, current 0): level + 1, saturating at max; further edges are ignored.
- levelClear_InLow = 0: level <= 0. Takes priority over a simultaneous levelUp edge.
- In RUN/PAUSE, a level change affects only the next reload. The countdown in progress is unchanged.
- Level changes never generate a tick.

Simultaneous events:
- Zero count plus pause in the same cycle: pause wins, tick is deferred until resume.
- Zero count plus level change in the same cycle: the reload uses the new level, because the register update and the reload read are combinational in the same edge.
  - Implementation detail: compute reload from the next-level value.

Outputs:
- tick, running and data are all registered.
- level_OutBUS = level register.

Decomposition:
- Package sc_downspeed_pkg:
  - state typedef/localparams: IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10.
  - reload-compute function with saturation to MIN_RELOAD.
- Sub-module sc_edgedetect_inlow: registered falling-edge detector (1-bit input, 1-cycle pulse out, async active-low reset to history 1).
  - Instantiated for levelUp.
  - Reusable for button inputs elsewhere.

Test Plan:
Bench parameters unless stated: DATAWIDTH = 8, LEVELWIDTH = 3, BASE = 9, STEP = 2, MIN = 2.
1. Reset, then start low for one cycle -> running = 1; data counts 9,8,...,0; tick one cycle after the 0; data reloads to 9; ticks every 10 cycles; level = 0.
2. Three levelUp presses in IDLE -> level = 3, data = 3. Fourth press -> level 4 (9-8 = 1 < MIN), data = 2. Seven presses total -> level 7, data = 2 (underflow clamp). Extra presses keep level = 7.
3. In RUN at data = 5, hold pause low 4 cycles -> data stays 5, tick = 0, running = 0. Release -> 4,3,... and tick arrives 6 cycles after release.
4. Pause asserted in the cycle data = 0 -> no tick. On release, tick on the next cycle and data = reload.
5. levelUp press while data = 6 at level 0 -> countdown continues 5..0 unchanged; next reload = 7; level = 1. levelClear low together with a levelUp edge -> level = 0.
6. Reset asserted asynchronously mid-count (data = 4, level = 2) -> data = 0, level = 0, tick = 0, running = 0 immediately, before the next clock. After release, start -> data = 9.
